// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus ready/valid decode port.
// master = fetch_queue side, slave = memory/decode side.
interface fetch_queue_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_pc;
  logic [DATA_WIDTH-1:0] out_ir;

  modport master (
    output mem_en, mem_addr, out_valid, out_pc, out_ir,
    input  mem_data, out_ready
  );
  modport slave (
    input  mem_en, mem_addr, out_valid, out_pc, out_ir,
    output mem_data, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch with DEPTH-entry prefetch queue, PC tagging and redirect squash.
// Optional FETCH_PERF_EN adds perf_fetched / perf_squashed counters.
module fetch_queue #(
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] BOOT_ADDR  = '0,
  parameter int                    DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    redirect,
  input  logic [DATA_WIDTH-1:0]   target,
  fetch_queue_if.master           bus,
  output logic [$clog2(DEPTH):0]  level
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]             perf_fetched,
  output logic [31:0]             perf_squashed
`endif
);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0]            fpc;
  logic [DATA_WIDTH-1:0]            inflight_pc;
  logic                             inflight;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] q_pc;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] q_ir;
  logic [PW-1:0]                    rd_ptr;
  logic [PW-1:0]                    wr_ptr;
  logic                             transfer;
  logic                             issue;
  logic                             push;

  assign bus.out_valid = !rst && (level != '0);
  assign transfer      = bus.out_valid && bus.out_ready;
  // Credit: the in-flight word already owns a slot, so count it against free space.
  assign issue         = !rst && !redirect &&
                         ((({1'b0, level} + (PW+2)'(inflight)) < (PW+2)'(DEPTH)) || transfer);
  assign push          = inflight && !redirect && !rst;
  assign bus.mem_en    = issue;
  assign bus.mem_addr  = fpc[ADDR_WIDTH-1:0];
  assign bus.out_pc    = bus.out_valid ? q_pc[rd_ptr] : '0;
  assign bus.out_ir    = bus.out_valid ? q_ir[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc         <= BOOT_ADDR;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      level       <= '0;
    end else if (redirect) begin
      fpc      <= target;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
    end else begin
      if (issue) begin
        fpc         <= fpc + DATA_WIDTH'(1);
        inflight_pc <= fpc;
      end
      inflight <= issue;
      if (push)     wr_ptr <= wr_ptr + PW'(1);
      if (transfer) rd_ptr <= rd_ptr + PW'(1);
      level <= level + (PW+1)'(push) - (PW+1)'(transfer);
    end
  end

  // Payload storage needs no reset; level gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr] <= inflight_pc;
      q_ir[wr_ptr] <= bus.mem_data;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      if (transfer) perf_fetched <= perf_fetched + 32'd1;
      if (redirect) perf_squashed <= perf_squashed + 32'(level) - 32'(transfer) + 32'(inflight);
    end
  end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized ready/redirect
// traffic scored against an expected-PC stream model (mem[a] = 0x100 + a).
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] target;
  logic [2:0]  level;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_squashed;
`endif
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_pc;

  fetch_queue_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) bus ();

  fetch_queue #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .BOOT_ADDR(32'h0), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .target(target), .bus(bus), .level(level)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_squashed(perf_squashed)
`endif
  );

  always #5 clk = ~clk;

  // 1-cycle latency instruction memory
  always @(posedge clk) if (bus.mem_en) bus.mem_data <= 32'h100 + {23'b0, bus.mem_addr};

  function automatic logic [31:0] ir_of(input logic [31:0] pc);
    return 32'h100 + {23'b0, pc[8:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; target = '0; bus.out_ready = 1'b1;
    tick(); tick();
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.mem_en !== 1'b0 || level !== 3'd0 || bus.out_pc !== 32'h0)
      begin errors++; $display("FAIL reset_state: valid=%b mem_en=%b level=%0d pc=%h required 0 0 0 0",
                               bus.out_valid, bus.mem_en, level, bus.out_pc); end
    rst = 1'b0; #1;
    checks++;
    if (bus.mem_en !== 1'b1 || bus.mem_addr !== 9'h0 || bus.out_valid !== 1'b0)
      begin errors++; $display("FAIL release_c0: mem_en=%b addr=%h valid=%b required 1 0 0",
                               bus.mem_en, bus.mem_addr, bus.out_valid); end
    tick(); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL release_c1: valid=%b required 0", bus.out_valid); end
    tick(); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_ir !== 32'h100)
      begin errors++; $display("FAIL release_c2: valid=%b pc=%h ir=%h required 1 0 100",
                               bus.out_valid, bus.out_pc, bus.out_ir); end
    tick();
    exp_pc = 32'h1;
  endtask

  task automatic test_stream();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_ir !== ir_of(exp_pc))
        begin errors++; $display("FAIL stream: valid=%b pc=%h ir=%h required 1 %h %h",
                                 bus.out_valid, bus.out_pc, bus.out_ir, exp_pc, ir_of(exp_pc)); end
      exp_pc++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_ir !== ir_of(exp_pc))
        begin errors++; $display("FAIL hold_head: valid=%b pc=%h required 1 %h", bus.out_valid, bus.out_pc, exp_pc); end
      tick();
    end
    #1;
    checks++;
    if (level !== 3'd4 || bus.mem_en !== 1'b0)
      begin errors++; $display("FAIL full_stall: level=%0d mem_en=%b required 4 0", level, bus.mem_en); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_ir !== ir_of(exp_pc))
        begin errors++; $display("FAIL drain: valid=%b pc=%h required 1 %h", bus.out_valid, bus.out_pc, exp_pc); end
      exp_pc++;
      tick();
    end
  endtask

  task automatic test_redirect_full();
    bus.out_ready = 1'b0;
    repeat (8) tick();
    checks++;
    if (level !== 3'd4) begin errors++; $display("FAIL prefill: level=%0d required 4", level); end
    redirect = 1'b1; target = 32'h40; #1;
    checks++;
    if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL redir_n: mem_en=%b required 0", bus.mem_en); end
    tick();
    redirect = 1'b0; #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.mem_en !== 1'b1 || bus.mem_addr !== 9'h40)
      begin errors++; $display("FAIL redir_n1: valid=%b mem_en=%b addr=%h required 0 1 040",
                               bus.out_valid, bus.mem_en, bus.mem_addr); end
    tick(); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL redir_n2: valid=%b required 0", bus.out_valid); end
    tick(); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h40 || bus.out_ir !== 32'h140)
      begin errors++; $display("FAIL redir_n3: valid=%b pc=%h ir=%h required 1 40 140",
                               bus.out_valid, bus.out_pc, bus.out_ir); end
    exp_pc = 32'h40;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (bus.out_pc !== exp_pc || bus.out_ir !== ir_of(exp_pc))
          begin errors++; $display("FAIL post_redir: pc=%h required %h", bus.out_pc, exp_pc); end
        exp_pc++;
      end
      tick();
    end
  endtask

  task automatic test_redirect_inflight();
    bit found;
    bus.out_ready = 1'b1;
    redirect = 1'b1; target = 32'h10; #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc)
      begin errors++; $display("FAIL redir_xfer: valid=%b pc=%h required 1 %h", bus.out_valid, bus.out_pc, exp_pc); end
    tick();
    redirect = 1'b0;
    found = 1'b0;
    for (int k = 1; k <= 8 && !found; k++) begin
      #1;
      if (bus.out_valid) begin
        found = 1'b1; checks++;
        if (bus.out_pc !== 32'h10 || k != 3)
          begin errors++; $display("FAIL redir_first: pc=%h cycle=%0d required 10 3", bus.out_pc, k); end
      end
      tick();
    end
    if (!found) begin errors++; checks++; $display("FAIL redir_first: timeout required valid"); end
    repeat (3) tick();
    redirect = 1'b1; target = 32'h10; tick();
    target = 32'h20; tick();
    redirect = 1'b0;
    found = 1'b0;
    for (int k = 1; k <= 8 && !found; k++) begin
      #1;
      if (bus.out_valid) begin
        found = 1'b1; checks++;
        if (bus.out_pc !== 32'h20 || bus.out_ir !== 32'h120 || k != 3)
          begin errors++; $display("FAIL b2b_redir: pc=%h cycle=%0d required 20 3", bus.out_pc, k); end
      end
      tick();
    end
    if (!found) begin errors++; checks++; $display("FAIL b2b_redir: timeout required valid"); end
    exp_pc = 32'h21;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      redirect      = ($urandom_range(0, 29) == 0);
      target        = $urandom;
      #1;
      checks++;
      if (bus.out_valid !== (level != 3'd0) || level > 3'd4)
        begin errors++; $display("FAIL rand_level: valid=%b level=%0d required valid=(level!=0), level<=4",
                                 bus.out_valid, level); end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (bus.out_pc !== exp_pc || bus.out_ir !== ir_of(exp_pc))
          begin errors++; $display("FAIL rand_stream: pc=%h ir=%h required %h %h",
                                   bus.out_pc, bus.out_ir, exp_pc, ir_of(exp_pc)); end
        exp_pc++;
      end
      if (redirect) exp_pc = target;
      tick();
    end
    redirect = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found;
    bus.out_ready = 1'b1;
    rst = 1'b1; tick(); rst = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      #1;
      if (bus.out_valid && bus.out_pc === 32'h7) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin errors++; $display("FAIL reach_pc7: timeout required pc 7"); end
    rst = 1'b1; #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.mem_en !== 1'b0)
      begin errors++; $display("FAIL rst_mid: valid=%b mem_en=%b required 0 0", bus.out_valid, bus.mem_en); end
    tick();
    rst = 1'b0; #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.mem_en !== 1'b1 || bus.mem_addr !== 9'h0)
      begin errors++; $display("FAIL rst_mid_next: valid=%b mem_en=%b addr=%h required 0 1 000",
                               bus.out_valid, bus.mem_en, bus.mem_addr); end
    tick(); tick(); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0)
      begin errors++; $display("FAIL rst_restart: valid=%b pc=%h required 1 0", bus.out_valid, bus.out_pc); end
    tick();
    redirect = 1'b1; target = 32'hFFFF_FFFF; tick();
    redirect = 1'b0; tick(); tick();
    exp_pc = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_ir !== ir_of(exp_pc))
        begin errors++; $display("FAIL pc_wrap: valid=%b pc=%h ir=%h required 1 %h %h",
                                 bus.out_valid, bus.out_pc, bus.out_ir, exp_pc, ir_of(exp_pc)); end
      exp_pc++;
      tick();
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    int n;
    rst = 1'b1; bus.out_ready = 1'b0; tick(); rst = 1'b0; #1;
    checks++;
    if (perf_fetched !== 32'd0 || perf_squashed !== 32'd0)
      begin errors++; $display("FAIL perf_reset: fetched=%0d squashed=%0d required 0 0", perf_fetched, perf_squashed); end
    n = 0;
    for (int k = 0; k < 40 && n < 5; k++) begin
      bus.out_ready = 1'b1; #1;
      if (bus.out_valid) n++;
      tick();
    end
    bus.out_ready = 1'b0;
    repeat (8) tick();
    redirect = 1'b1; target = 32'h40; tick();
    redirect = 1'b0; #1;
    checks++;
    if (perf_fetched !== 32'd5 || perf_squashed !== 32'd4)
      begin errors++; $display("FAIL perf_counts: fetched=%0d squashed=%0d required 5 4", perf_fetched, perf_squashed); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_redirect_inflight();
    test_random();
    test_reset_mid();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule
